serial_frame_receiver: RTL and testbench

//  Framed serial-to-parallel receiver. Sits directly downstream of the N-stage

---
 rtl/serial_frame_receiver.sv | 112 +++++++++++
 tb/tb_serial_frame_receiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// Framed serial-to-parallel receiver: start, N data bits MSB-first, parity, stop(0); word shown 1 cycle after stop sample.
// Backpressure: one holding register on valid/ready; a good word arriving while it is full and not draining is dropped with an overrun pulse.
module serial_frame_receiver #(
  parameter int N           = 4,
  parameter bit PARITY_EVEN = 1'b1
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         in,
  input  logic         bit_en,
  output logic [N-1:0] data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_sreg;
  logic           r_par;
  logic [N-1:0]   r_data;
  logic           r_valid;
  logic           r_perr;
  logic           r_ferr;
  logic           r_ovr;

  logic           w_stop_eval;
  logic           w_perr;
  logic           w_ferr;
  logic           w_good;
  logic           w_load;
  logic           w_ovr;

  always_comb begin
    w_state_nxt = r_state;
    w_stop_eval = 1'b0;
    case (r_state)
      S_IDLE:   if (bit_en && in) w_state_nxt = S_DATA;
      S_DATA:   if (bit_en && (r_cnt == CW'(N - 1))) w_state_nxt = S_PARITY;
      S_PARITY: if (bit_en) w_state_nxt = S_STOP;
      S_STOP: begin
        if (bit_en) begin
          w_state_nxt = S_IDLE;
          w_stop_eval = 1'b1;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Parity is a mismatch when the XOR over data and parity bit differs from the selected sense.
  assign w_perr = (^{r_sreg, r_par}) ^ ~PARITY_EVEN;
  assign w_ferr = in;
  assign w_good = w_stop_eval & ~w_perr & ~w_ferr;
  assign w_load = w_good & (~r_valid | out_ready);
  assign w_ovr  = w_good & r_valid & ~out_ready;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_par   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_perr  <= w_stop_eval & w_perr;
      r_ferr  <= w_stop_eval & w_ferr;
      r_ovr   <= w_ovr;
      if (bit_en) begin
        case (r_state)
          S_IDLE:   if (in) r_cnt <= '0;
          S_DATA: begin
            r_sreg <= {r_sreg[N-2:0], in};
            r_cnt  <= r_cnt + 1'b1;
          end
          S_PARITY: r_par <= in;
          default:  ;
        endcase
      end
      if (w_load) begin
        r_data  <= r_sreg;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out   = r_data;
  assign out_valid  = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: frame-level model compared every cycle, plus literal checks.
module tb_serial_frame_receiver;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clear_n;
  logic         in;
  logic         bit_en;
  logic [N-1:0] data_out;
  logic         out_valid;
  logic         out_ready;
  logic         parity_err;
  logic         frame_err;
  logic         overrun;

  int total = 0;
  int bad   = 0;

  serial_frame_receiver #(.N(N), .PARITY_EVEN(1'b1)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .in         (in),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: collect the bits after a start bit, judge the frame once complete.
  logic         m_started = 1'b0;
  logic         m_in_frame = 1'b0;
  logic         q_bits[$];
  logic [N-1:0] m_data = '0;
  logic         m_valid = 1'b0;
  logic         m_perr = 1'b0;
  logic         m_ferr = 1'b0;
  logic         m_ovr = 1'b0;

  always @(posedge clk) begin : model
    int ones;
    logic [N-1:0] word;
    logic took, load, pe, fe;
    m_started = 1'b1;
    if (!clear_n) begin
      m_in_frame = 1'b0;
      q_bits.delete();
      m_data = '0; m_valid = 1'b0;
      m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      took = m_valid && out_ready;
      load = 1'b0;
      m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      if (bit_en) begin
        if (!m_in_frame) begin
          if (in) begin
            m_in_frame = 1'b1;
            q_bits.delete();
          end
        end else begin
          q_bits.push_back(in);
          if (q_bits.size() == N + 2) begin
            m_in_frame = 1'b0;
            ones = 0;
            word = '0;
            for (int i = 0; i < N; i++) word[N-1-i] = q_bits[i];
            for (int i = 0; i <= N; i++) ones += int'(q_bits[i]);
            pe = (ones % 2) != 0;
            fe = q_bits[N+1];
            m_perr = pe;
            m_ferr = fe;
            if (!pe && !fe) begin
              if (!m_valid || out_ready) begin
                m_data = word;
                load = 1'b1;
              end else begin
                m_ovr = 1'b1;
              end
            end
          end
        end
      end
      if (load) m_valid = 1'b1;
      else if (took) m_valid = 1'b0;
    end
  end

  logic [N-1:0] got[$];

  always @(negedge clk) begin
    if (m_started) begin
      chk("data_out", 32'(data_out), 32'(m_data));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("parity_err", 32'(parity_err), 32'(m_perr));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(data_out);
    end
  end

  task automatic bitc(input logic b, input logic en);
    in = b;
    bit_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bitc(1'b0, 1'b1);
  endtask

  task automatic frame(input logic [3:0] d, input logic p, input logic stop, input bit gap);
    logic [6:0] b;
    b = {1'b1, d, p, stop};
    for (int i = 6; i >= 0; i--) begin
      bitc(b[i], 1'b1);
      if (gap && i != 0) bitc(1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    logic [N-1:0] exp_seq[$];
    logic [5:0] b6;
    clear_n = 1'b0; in = 1'b1; bit_en = 1'b1; out_ready = 1'b1;
    repeat (3) bitc(1'b1, 1'b1);
    chk("reset_data", 32'(data_out), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_flags", 32'({parity_err, frame_err, overrun}), 32'h0);
    clear_n = 1'b1;
    idle(2);

    // Good frame 4'b1010 with even parity bit 0.
    frame(4'hA, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(data_out), 32'hA);
    chk("t1_flags", 32'({parity_err, frame_err, overrun}), 32'h0);
    idle(1);
    chk("t1_drained", 32'(out_valid), 32'h0);
    chk("t1_data_kept", 32'(data_out), 32'hA);

    frame(4'hA, 1'b1, 1'b0, 1'b0);
    chk("t2_perr", 32'(parity_err), 32'h1);
    chk("t2_nvalid", 32'(out_valid), 32'h0);
    idle(1);
    chk("t2_perr_pulse", 32'(parity_err), 32'h0);
    frame(4'hA, 1'b0, 1'b1, 1'b0);
    chk("t2_ferr", 32'({parity_err, frame_err}), 32'h1);
    idle(1);
    frame(4'hA, 1'b1, 1'b1, 1'b0);
    chk("t2_both", 32'({parity_err, frame_err}), 32'h3);
    idle(1);

    out_ready = 1'b0;
    frame(4'hA, 1'b0, 1'b0, 1'b0);
    frame(4'h5, 1'b0, 1'b0, 1'b0);
    chk("t3_ovr", 32'(overrun), 32'h1);
    chk("t3_held", 32'(data_out), 32'hA);
    chk("t3_valid", 32'(out_valid), 32'h1);
    idle(1);
    chk("t3_ovr_pulse", 32'(overrun), 32'h0);
    out_ready = 1'b1;
    idle(2);

    frame(4'hC, 1'b0, 1'b0, 1'b1);
    frame(4'h7, 1'b1, 1'b0, 1'b1);
    chk("t4_gap_data", 32'(data_out), 32'h7);
    frame(4'hE, 1'b1, 1'b0, 1'b0);
    frame(4'h6, 1'b0, 1'b0, 1'b0);
    chk("t4_b2b_data", 32'(data_out), 32'h6);
    idle(2);

    out_ready = 1'b0;
    frame(4'h9, 1'b0, 1'b0, 1'b0);
    bitc(1'b1, 1'b1); bitc(1'b1, 1'b1); bitc(1'b0, 1'b1);
    clear_n = 1'b0;
    bitc(1'b1, 1'b1);
    chk("t5_rst_out", 32'({data_out, out_valid, parity_err, frame_err, overrun}), 32'h0);
    bitc(1'b1, 1'b1);
    clear_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    chk("t5_after_rst", 32'({data_out, out_valid}), 32'h0);
    frame(4'h3, 1'b0, 1'b0, 1'b0);
    chk("t5_data", 32'(data_out), 32'h3);
    idle(2);

    out_ready = 1'b0;
    frame(4'h5, 1'b0, 1'b0, 1'b0);
    b6 = {1'b1, 4'hB, 1'b1};
    for (int i = 5; i >= 0; i--) bitc(b6[i], 1'b1);
    out_ready = 1'b1;
    bitc(1'b0, 1'b1);
    chk("t6_valid", 32'(out_valid), 32'h1);
    chk("t6_data", 32'(data_out), 32'hB);
    chk("t6_novr", 32'(overrun), 32'h0);
    idle(2);

    exp_seq = '{4'hA, 4'hA, 4'hC, 4'h7, 4'hE, 4'h6, 4'h3, 4'h5, 4'hB};
    chk("deliv_count", 32'(got.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size(); i++) begin
      if (i < got.size()) chk($sformatf("deliv_%0d", i), 32'(got[i]), 32'(exp_seq[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
